// File: rtl/axis_cobs_encode_if.sv
// Byte-wide AXI-Stream link with a one-bit tuser, used for both sides of the COBS encoder.
interface axis_cobs_encode_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_cobs_encode.sv
// Half-duplex COBS encoder: buffers up to 254 nonzero bytes, then emits code byte,
// buffered data, optional 0x01 trailer and optional 0x00 delimiter.
module axis_cobs_encode #(
   parameter bit APPEND_ZERO = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   axis_cobs_encode_if.slave    s_axis,
   axis_cobs_encode_if.master   m_axis
);

   typedef enum logic [2:0] {StFill, StCode, StData, StTrail, StDelim} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] rptr_q, rptr_d;
   logic       final_q, final_d;
   logic       trail_q, trail_d;
   logic       err_q, err_d;
   logic [7:0] seg_mem [254];

   logic s_hs, m_hs, last_data, close, post, done;

   assign s_axis.tready = !rst && (state_q == StFill);
   assign m_axis.tvalid = !rst && (state_q != StFill);
   assign s_hs          = s_axis.tvalid && s_axis.tready;
   assign m_hs          = m_axis.tvalid && m_axis.tready;
   assign last_data     = (rptr_q == cnt_q - 8'd1);

   // Output byte and end-of-frame marking
   always_comb begin
      m_axis.tdata = 8'h00;
      m_axis.tlast = 1'b0;
      unique case (state_q)
         StCode: begin
            m_axis.tdata = cnt_q + 8'd1;
            m_axis.tlast = (cnt_q == 8'd0) && final_q && !trail_q && !APPEND_ZERO;
         end
         StData: begin
            m_axis.tdata = seg_mem[rptr_q];
            m_axis.tlast = last_data && final_q && !trail_q && !APPEND_ZERO;
         end
         StTrail: begin
            m_axis.tdata = 8'h01;
            m_axis.tlast = !APPEND_ZERO;
         end
         StDelim: begin
            m_axis.tdata = 8'h00;
            m_axis.tlast = 1'b1;
         end
         default: ;
      endcase
      if (rst) m_axis.tlast = 1'b0;
      m_axis.tuser = m_axis.tlast && err_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rptr_d  = rptr_q;
      final_d = final_q;
      trail_d = trail_q;
      err_d   = err_q;
      close   = 1'b0;
      post    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StFill: begin
            if (s_hs) begin
               if (s_axis.tdata != 8'h00) begin
                  cnt_d = cnt_q + 8'd1;
                  close = (cnt_q == 8'd253) || s_axis.tlast;
               end else begin
                  close = 1'b1;
                  if (s_axis.tlast) trail_d = 1'b1;
               end
               if (close) begin
                  state_d = StCode;
                  if (s_axis.tlast) begin
                     final_d = 1'b1;
                     err_d   = s_axis.tuser;
                  end
               end
            end
         end
         StCode: begin
            if (m_hs) begin
               rptr_d = 8'd0;
               if (cnt_q != 8'd0) state_d = StData;
               else               post    = 1'b1;
            end
         end
         StData: begin
            if (m_hs) begin
               if (last_data) post   = 1'b1;
               else           rptr_d = rptr_q + 8'd1;
            end
         end
         StTrail: begin
            if (m_hs) begin
               if (APPEND_ZERO) state_d = StDelim;
               else             done    = 1'b1;
            end
         end
         StDelim: begin
            if (m_hs) done = 1'b1;
         end
         default: state_d = StFill;
      endcase

      // A segment has drained: continue the frame, or finish it
      if (post) begin
         if (!final_q) begin
            state_d = StFill;
            cnt_d   = 8'd0;
         end else if (trail_q) begin
            state_d = StTrail;
         end else if (APPEND_ZERO) begin
            state_d = StDelim;
         end else begin
            done = 1'b1;
         end
      end

      if (done) begin
         state_d = StFill;
         cnt_d   = 8'd0;
         final_d = 1'b0;
         trail_d = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFill;
         cnt_q   <= 8'd0;
         rptr_q  <= 8'd0;
         final_q <= 1'b0;
         trail_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rptr_q  <= rptr_d;
         final_q <= final_d;
         trail_q <= trail_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (s_hs && (s_axis.tdata != 8'h00)) seg_mem[cnt_q] <= s_axis.tdata;
   end

endmodule

// File: tb/tb_axis_cobs_encode.sv
// Directed and randomized-stall checks for axis_cobs_encode with and without the delimiter.
module tb_axis_cobs_encode;

   typedef logic [7:0] bq_t[$];
   typedef logic [9:0] beat_q_t[$];   // {tuser, tlast, tdata}

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] s_tdata = 8'h00;
   logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, sel = 1'b0;
   logic       m_tready;
   bit         rnd_ready = 1'b0;
   beat_q_t    got;
   int         hd_viol = 0;

   axis_cobs_encode_if a_s ();
   axis_cobs_encode_if a_m ();
   axis_cobs_encode_if b_s ();
   axis_cobs_encode_if b_m ();

   assign a_s.tdata  = s_tdata;
   assign a_s.tlast  = s_tlast;
   assign a_s.tuser  = s_tuser;
   assign a_s.tvalid = s_tvalid && !sel;
   assign b_s.tdata  = s_tdata;
   assign b_s.tlast  = s_tlast;
   assign b_s.tuser  = s_tuser;
   assign b_s.tvalid = s_tvalid && sel;
   assign a_m.tready = m_tready;
   assign b_m.tready = m_tready;

   axis_cobs_encode #(.APPEND_ZERO(1'b1)) u_dut_a (.clk(clk), .rst(rst), .s_axis(a_s), .m_axis(a_m));
   axis_cobs_encode #(.APPEND_ZERO(1'b0)) u_dut_b (.clk(clk), .rst(rst), .s_axis(b_s), .m_axis(b_m));

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (a_m.tvalid && m_tready) got.push_back({a_m.tuser, a_m.tlast, a_m.tdata});
         if (b_m.tvalid && m_tready) got.push_back({b_m.tuser, b_m.tlast, b_m.tdata});
         if ((a_m.tvalid && a_s.tready) || (b_m.tvalid && b_s.tready)) hd_viol++;
      end
   end

   function automatic beat_q_t cobs_model(input bq_t d, input bit user, input bit az);
      beat_q_t    o;
      bq_t        blk;
      logic [9:0] t;
      for (int i = 0; i < d.size(); i++) begin
         bit last = (i == d.size() - 1);
         if (d[i] != 8'h00) begin
            blk.push_back(d[i]);
            if (blk.size() == 254 || last) begin
               o.push_back({2'b00, 8'(blk.size() + 1)});
               foreach (blk[j]) o.push_back({2'b00, blk[j]});
               blk.delete();
            end
         end else begin
            o.push_back({2'b00, 8'(blk.size() + 1)});
            foreach (blk[j]) o.push_back({2'b00, blk[j]});
            blk.delete();
            if (last) o.push_back(10'h001);
         end
      end
      if (az) o.push_back(10'h000);
      t = o.pop_back();
      t[9:8] = {user, 1'b1};
      o.push_back(t);
      return o;
   endfunction

   task automatic send_frame(input bit s, input bq_t d, input bit user);
      bit hs;
      int n;
      sel = s;
      for (int i = 0; i < d.size(); i++) begin
         hs = 1'b0;
         n  = 0;
         s_tdata  = d[i];
         s_tlast  = (i == d.size() - 1);
         s_tuser  = user && s_tlast;
         s_tvalid = 1'b1;
         while (!hs && n < 3000) begin
            @(negedge clk);
            hs = s ? b_s.tready : a_s.tready;
            @(posedge clk);
            #1;
            n++;
         end
         if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte %0d: s_axis_tready never rose", i);
            s_tvalid = 1'b0;
            return;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      int t = 0;
      while (got.size() < n && t < 5000) begin
         @(posedge clk);
         t++;
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({a_m.tvalid, a_m.tlast, a_m.tuser, a_s.tready, b_m.tvalid, b_s.tready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b required 000000",
                  {a_m.tvalid, a_m.tlast, a_m.tuser, a_s.tready, b_m.tvalid, b_s.tready});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_s.tready, a_m.tvalid, b_s.tready, b_m.tvalid} !== 4'b1010) begin
         errors++;
         $display("FAIL reset_release got %b required 1010",
                  {a_s.tready, a_m.tvalid, b_s.tready, b_m.tvalid});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_short_frames();
      bq_t     d;
      beat_q_t exp;
      bit      s, u;
      for (int v = 0; v < 6; v++) begin
         case (v)
            0: begin s = 0; u = 0; d = '{8'h11};              exp = '{10'h002, 10'h011, 10'h100}; end
            1: begin s = 0; u = 0; d = '{8'h00};              exp = '{10'h001, 10'h001, 10'h100}; end
            2: begin s = 0; u = 0; d = '{8'h11, 8'h00, 8'h22};
                     exp = '{10'h002, 10'h011, 10'h002, 10'h022, 10'h100}; end
            3: begin s = 1; u = 1; d = '{8'h33};              exp = '{10'h002, 10'h333}; end
            4: begin s = 0; u = 1; d = '{8'h44};              exp = '{10'h002, 10'h044, 10'h300}; end
            default: begin s = 1; u = 0; d = '{8'h00};        exp = '{10'h001, 10'h101}; end
         endcase
         got.delete();
         send_frame(s, d, u);
         wait_beats(exp.size());
         checks++;
         if (got.size() !== exp.size()) begin
            errors++;
            $display("FAIL short%0d_len got %0d required %0d", v, got.size(), exp.size());
         end
         for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
               errors++;
               $display("FAIL short%0d_beat%0d got %h required %h", v, i, got[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_long_frames();
      bq_t     d;
      beat_q_t exp;
      bit      s;
      for (int v = 0; v < 4; v++) begin
         d.delete();
         exp.delete();
         s = (v == 3);
         if (v == 1) for (int i = 0; i < 255; i++) d.push_back(8'(i + 1));
         else        for (int i = 0; i < 254; i++) d.push_back(8'(i + 1));
         if (v == 2) d.push_back(8'h00);
         exp.push_back(10'h0FF);
         for (int i = 0; i < 254; i++) exp.push_back({2'b00, 8'(i + 1)});
         case (v)
            0: exp.push_back(10'h100);
            1: begin exp.push_back(10'h002); exp.push_back(10'h0FF); exp.push_back(10'h100); end
            2: begin exp.push_back(10'h001); exp.push_back(10'h001); exp.push_back(10'h100); end
            default: begin void'(exp.pop_back()); exp.push_back(10'h1FE); end
         endcase
         got.delete();
         send_frame(s, d, 1'b0);
         wait_beats(exp.size());
         checks++;
         if (got.size() !== exp.size()) begin
            errors++;
            $display("FAIL long%0d_len got %0d required %0d", v, got.size(), exp.size());
         end
         for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
               errors++;
               $display("FAIL long%0d_beat%0d got %h required %h", v, i, got[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_latency();
      bq_t  d = '{8'h11, 8'h22, 8'h33};
      logic [7:0] ev [5] = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h00};
      got.delete();
      send_frame(1'b0, d, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({a_m.tvalid, a_s.tready, a_m.tdata, a_m.tlast} !== {2'b10, ev[k], k == 4}) begin
            errors++;
            $display("FAIL latency_cyc%0d got v=%b rdy=%b d=%h l=%b required v=1 rdy=0 d=%h l=%b",
                     k, a_m.tvalid, a_s.tready, a_m.tdata, a_m.tlast, ev[k], k == 4);
         end
      end
      @(negedge clk);
      checks++;
      if ({a_m.tvalid, a_s.tready} !== 2'b01) begin
         errors++;
         $display("FAIL latency_idle got v=%b rdy=%b required v=0 rdy=1", a_m.tvalid, a_s.tready);
      end
      @(posedge clk);
      #1;
      got.delete();
   endtask

   task automatic test_stall_reset();
      bq_t     d;
      beat_q_t exp;
      rnd_ready = 1'b1;
      d = '{8'h05, 8'h00, 8'h06};
      for (int i = 0; i < 40; i++) d.push_back(8'(i + 8'h40));
      got.delete();
      send_frame(1'b0, d, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_m.tvalid, a_m.tlast, a_m.tuser, a_s.tready} !== 4'b0) begin
         errors++;
         $display("FAIL midreset_outputs got %b required 0000",
                  {a_m.tvalid, a_m.tlast, a_m.tuser, a_s.tready});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      @(negedge clk);
      checks++;
      if ({a_s.tready, a_m.tvalid} !== 2'b10) begin
         errors++;
         $display("FAIL midreset_release got rdy=%b v=%b required rdy=1 v=0", a_s.tready, a_m.tvalid);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (got.size() !== 0) begin
         errors++;
         $display("FAIL midreset_stale got %0d beats required 0", got.size());
      end
      hd_viol = 0;
      for (int f = 0; f < 5; f++) begin
         bit u = 1'($urandom_range(0, 1));
         int len = (f == 0) ? 260 : $urandom_range(1, 120);
         d.delete();
         for (int i = 0; i < len; i++)
            d.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
         exp = cobs_model(d, u, 1'b1);
         got.delete();
         send_frame(1'b0, d, u);
         wait_beats(exp.size());
         checks++;
         if (got.size() !== exp.size()) begin
            errors++;
            $display("FAIL stall%0d_len got %0d required %0d", f, got.size(), exp.size());
         end
         for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
               errors++;
               $display("FAIL stall%0d_beat%0d got %h required %h", f, i, got[i], exp[i]);
            end
         end
      end
      checks++;
      if (hd_viol !== 0) begin
         errors++;
         $display("FAIL half_duplex got %0d overlap cycles required 0", hd_viol);
      end
      rnd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_short_frames();
      test_long_frames();
      test_latency();
      test_stall_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_cobs_encode.md
AXIS_COBS_ENCODE -- requirements
Module: axis_cobs_encode

Interface
REQ-001 Parameter APPEND_ZERO, default 1, SHALL mean: 1 = append a 0x00 delimiter to each encoded frame; 0 = no delimiter.
REQ-002 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 s_axis_tdata  input  8  SHALL carry a raw frame byte.
REQ-005 s_axis_tvalid  input  1  SHALL mark an input beat as valid.
REQ-006 s_axis_tready  output  1  SHALL mark that the encoder accepts the input beat.
REQ-007 s_axis_tlast  input  1  SHALL mark the last byte of a raw frame.
REQ-008 s_axis_tuser  input  1  SHALL flag a bad frame; it is sampled only on the tlast beat.
REQ-009 m_axis_tdata  output  8  SHALL carry an encoded byte.
REQ-010 m_axis_tvalid  output  1  SHALL mark an output beat as valid.
REQ-011 m_axis_tready  input  1  SHALL mark that downstream accepts the output beat.
REQ-012 m_axis_tlast  output  1  SHALL mark the last byte of an encoded frame.
REQ-013 m_axis_tuser  output  1  SHALL carry the frame's tuser value on the tlast beat and 0 on all other beats.

Function
REQ-014 Transfers SHALL follow AXI-Stream rules: a transfer occurs when valid and ready are both high; m_axis_tdata, m_axis_tlast and m_axis_tuser SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-015 The block SHALL hold a 254x8 segment buffer, an 8-bit fill count cnt (0..254), an 8-bit read pointer, and flags final, trail, err.
REQ-016 The FSM states SHALL be FILL, CODE, DATA, TRAIL and DELIM; reset state SHALL be FILL.
REQ-017 In FILL, s_axis_tready SHALL be 1; in all other states it SHALL be 0 (half-duplex: no input is accepted while a segment drains).
REQ-018 FILL, nonzero byte accepted: write buf[cnt], then cnt+1; go to CODE when the new cnt=254 or tlast=1.
REQ-019 FILL, zero byte accepted: the byte SHALL NOT be stored; go to CODE; if tlast=1, set trail.
REQ-020 On the closing beat, err SHALL latch s_axis_tuser if tlast=1; final SHALL be set if tlast=1.
REQ-021 CODE SHALL present cnt+1 (0x01..0xFF); on accept go to DATA if cnt>0, otherwise to the post-segment step.
REQ-022 DATA SHALL present buf[0..cnt-1] in order; after the last byte is accepted, go to the post-segment step.
REQ-023 Post-segment step: !final -> FILL with cnt=0; final&&trail -> TRAIL; final&&!trail -> DELIM if APPEND_ZERO=1, otherwise frame done (FILL).
REQ-024 TRAIL SHALL present 0x01; on accept go to DELIM if APPEND_ZERO=1, otherwise frame done.
REQ-025 DELIM SHALL present 0x00; on accept the frame is done: go to FILL and clear cnt, final, trail and err.
REQ-026 m_axis_tlast SHALL be 1 only on the last encoded byte, and m_axis_tuser=err on that byte.
- Last byte = the 0x00 delimiter when APPEND_ZERO=1.
- Otherwise it is the final TRAIL, DATA or CODE byte.
REQ-027 A 254-byte segment (code 0xFF) SHALL imply no zero; a new segment SHALL follow unless final is set, and no 0x01 trailer SHALL be added when a 0xFF segment closes on tlast.
REQ-028 Latency: the code byte SHALL be valid on m_axis the cycle after the closing input beat is accepted.
REQ-029 With m_axis_tready held at 1, CODE/DATA/TRAIL/DELIM SHALL each emit one byte per cycle with no bubbles.
REQ-030 Stalls on m_axis_tready SHALL neither lose nor duplicate bytes.

Reset
REQ-031 While rst=1, the block SHALL drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0 and s_axis_tready=0.
REQ-032 While rst=1, it SHALL set state=FILL and clear cnt, the read pointer, final, trail and err.
REQ-033 s_axis_tready SHALL be 1 on the first cycle after rst deasserts.
REQ-034 Reset in mid-frame SHALL discard all buffered and partially emitted data; no output beat SHALL appear until new input arrives.
REQ-035 Buffer contents need no reset.

Verification
REQ-036 Input {0x11} tlast, APPEND_ZERO=1 -> output 02 11 00; tlast on the 00 byte; tuser=0.
REQ-037 Input {0x00} tlast -> output 01 01 00; input {0x11,0x00,0x22} tlast -> output 02 11 02 22 00.
REQ-038 Input 254 bytes 0x01..0xFE tlast -> output FF, the 254 bytes, then 00; total 256 beats; no 0x01 trailer.
REQ-039 Input 255 nonzero bytes tlast -> output FF, 254 bytes, 02, the last byte, then 00.
REQ-040 Input {0x33} tlast with tuser=1 and APPEND_ZERO=0 -> output 02 33; tlast=1 and tuser=1 on the 33 byte.
REQ-041 m_axis_tready randomly toggled at 50%, together with a rst pulse mid-drain -> output matches the reference model for all frames after reset; no beat is dropped; s_axis_tready=0 during every drain.
